// File: rtl/tut4_verilog_regincr_pkg.sv
// Shared constants and helpers for the tut4 registered-incrementer slice.
// Holds the default message width and the pointer-width helper; queue
// state lives in the queue modules themselves.
package tut4_verilog_regincr_pkg;

    // Width of the messages handled by the registered incrementer.
    localparam int unsigned c_nbits = 8;

    // Bits needed to index a buffer of n entries (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tut4_verilog_regincr_input_queue_ctrl.sv
// Control path of the incrementer input queue: head/tail pointers,
// occupancy count, val/rdy handshakes and storage write/read selects.
// Optional feature: TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN lets an
// empty queue forward the incoming message combinationally.
module tut4_verilog_regincr_input_queue_ctrl
    import tut4_verilog_regincr_pkg::*;
#(
    parameter  int unsigned p_num_entries = 4,
    localparam int unsigned c_ptr_nbits   = ptr_width(p_num_entries),
    localparam int unsigned c_cnt_nbits   = $clog2(p_num_entries) + 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    output logic                   deq_val,
    input  logic                   deq_rdy,
    output logic [c_cnt_nbits-1:0] num_free_entries,
    output logic                   wen,
    output logic [c_ptr_nbits-1:0] waddr,
    output logic [c_ptr_nbits-1:0] raddr
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
    ,
    output logic                   bypass_sel
`endif
);

    localparam logic [c_cnt_nbits-1:0] c_depth = c_cnt_nbits'(p_num_entries);
    localparam logic [c_ptr_nbits-1:0] c_one   = c_ptr_nbits'(1);

    logic [c_ptr_nbits-1:0] head;
    logic [c_ptr_nbits-1:0] tail;
    logic [c_cnt_nbits-1:0] count;
    logic [c_cnt_nbits-1:0] count_next;
    logic                   full;
    logic                   empty;
    logic                   ren;

    // Occupancy flags come from the explicit count, never pointer equality.
    assign full  = (count == c_depth);
    assign empty = (count == '0);

    // Handshake decode: readiness, validity, and which side touches storage.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        enq_rdy = !full;
        deq_val = !empty;
        wen     = enq_val && !full;
        ren     = !empty && deq_rdy;
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
        bypass_sel = empty && enq_val && !reset;
        if (empty) begin
            deq_val = enq_val && !reset;
            // A forwarded message that is consumed this cycle is never stored.
            if (deq_rdy) begin
                wen = 1'b0;
            end
        end
`endif
        count_next = count + c_cnt_nbits'(wen) - c_cnt_nbits'(ren);
    end

    // Pointer and occupancy registers; reset discards everything queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            if (wen) begin
                tail <= tail + c_one;
            end
            if (ren) begin
                head <= head + c_one;
            end
            count <= count_next;
        end
    end

    assign num_free_entries = c_depth - count;
    assign waddr            = tail;
    assign raddr            = head;

endmodule

// File: rtl/tut4_verilog_regincr_input_queue.sv
// Input queue in front of the registered incrementer: a p_num_entries-deep
// FIFO with val/rdy on both sides. Storage lives here; pointers, count and
// handshakes live in tut4_verilog_regincr_input_queue_ctrl.
// Optional feature: TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN (empty-queue
// combinational bypass). Default build has no enq-to-deq combinational path.
module tut4_verilog_regincr_input_queue
    import tut4_verilog_regincr_pkg::*;
#(
    parameter int unsigned p_nbits       = c_nbits,
    parameter int unsigned p_num_entries = 4
)(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enq_val,
    output logic                               enq_rdy,
    input  logic [p_nbits-1:0]                 enq_msg,
    output logic                               deq_val,
    input  logic                               deq_rdy,
    output logic [p_nbits-1:0]                 deq_msg,
    output logic [$clog2(p_num_entries):0]     num_free_entries
);

    localparam int unsigned c_ptr_nbits = ptr_width(p_num_entries);

    logic [p_nbits-1:0]     entries [p_num_entries];
    logic                   wen;
    logic [c_ptr_nbits-1:0] waddr;
    logic [c_ptr_nbits-1:0] raddr;
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
    logic                   bypass_sel;
`endif

    tut4_verilog_regincr_input_queue_ctrl #(
        .p_num_entries (p_num_entries)
    ) ctrl (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (enq_val),
        .enq_rdy          (enq_rdy),
        .deq_val          (deq_val),
        .deq_rdy          (deq_rdy),
        .num_free_entries (num_free_entries),
        .wen              (wen),
        .waddr            (waddr),
        .raddr            (raddr)
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
        ,
        .bypass_sel       (bypass_sel)
`endif
    );

    // Message storage; written at the tail on each stored enqueue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: storage is cleared on reset so the head reads 0 while idle; plain RAM would not be.
            for (int i = 0; i < p_num_entries; i++) begin
                entries[i] <= '0;
            end
        end else if (wen) begin
            entries[waddr] <= enq_msg;
        end
    end

    // Head message, or the incoming message when bypassing an empty queue.
    always_comb begin
        deq_msg = entries[raddr];
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
        if (bypass_sel) begin
            deq_msg = enq_msg;
        end
`endif
    end

endmodule

// File: tb/tb_tut4_verilog_regincr_input_queue.sv
// Directed self-checking bench for tut4_verilog_regincr_input_queue
// (p_nbits=8, p_num_entries=4). Bypass-dependent expectations follow
// TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN.
module tb_tut4_verilog_regincr_input_queue;

    logic       clk = 1'b0;
    logic       reset;
    logic       enq_val;
    logic       enq_rdy;
    logic [7:0] enq_msg;
    logic       deq_val;
    logic       deq_rdy;
    logic [7:0] deq_msg;
    logic [2:0] num_free_entries;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tut4_verilog_regincr_input_queue #(
        .p_nbits       (8),
        .p_num_entries (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (enq_val),
        .enq_rdy          (enq_rdy),
        .enq_msg          (enq_msg),
        .deq_val          (deq_val),
        .deq_rdy          (deq_rdy),
        .deq_msg          (deq_msg),
        .num_free_entries (num_free_entries)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        enq_val = 1'b0;
        enq_msg = 8'h00;
        deq_rdy = 1'b0;
        #2;
        check("rst_enq_rdy", 32'(enq_rdy), 32'd1);
        check("rst_deq_val", 32'(deq_val), 32'd0);
        check("rst_num_free", 32'(num_free_entries), 32'd4);
        check("rst_deq_msg", 32'(deq_msg), 32'h00);
        tick();
        reset = 1'b0;
        tick();

        // Single enqueue of 0x05, then dequeue.
        enq_val = 1'b1;
        enq_msg = 8'h05;
        #1;
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
        check("byp_hold_deq_val", 32'(deq_val), 32'd1);
`else
        check("enq05_no_comb_path", 32'(deq_val), 32'd0);
`endif
        tick();
        enq_val = 1'b0;
        enq_msg = 8'h5A;
        #1;
        check("enq05_deq_val", 32'(deq_val), 32'd1);
        check("enq05_deq_msg", 32'(deq_msg), 32'h05);
        check("enq05_num_free", 32'(num_free_entries), 32'd3);
        deq_rdy = 1'b1;
        tick();
        deq_rdy = 1'b0;
        check("deq05_deq_val", 32'(deq_val), 32'd0);
        check("deq05_num_free", 32'(num_free_entries), 32'd4);

        // Fill to full with 0x01..0x04, offer 0x09 while full, then drain.
        for (int i = 1; i <= 4; i++) begin
            enq_val = 1'b1;
            enq_msg = 8'(i);
            tick();
        end
        check("full_enq_rdy", 32'(enq_rdy), 32'd0);
        check("full_num_free", 32'(num_free_entries), 32'd0);
        enq_msg = 8'h09;
        tick();
        enq_val = 1'b0;
        check("full_reject_num_free", 32'(num_free_entries), 32'd0);
        check("full_reject_head", 32'(deq_msg), 32'h01);
        deq_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_deq_val", 32'(deq_val), 32'd1);
            check("drain_deq_msg", 32'(deq_msg), 32'(i));
            tick();
        end
        check("drained_deq_val", 32'(deq_val), 32'd0);
        check("drained_num_free", 32'(num_free_entries), 32'd4);

        // Ten back-to-back messages with the consumer always ready (wraps twice).
        for (int i = 0; i < 10; i++) begin
            enq_val = 1'b1;
            enq_msg = 8'(8'h10 + i);
            #1;
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
            check("b2b_byp_deq_val", 32'(deq_val), 32'd1);
            check("b2b_byp_deq_msg", 32'(deq_msg), 32'(8'h10 + i));
`else
            if (i == 0) begin
                check("b2b_first_deq_val", 32'(deq_val), 32'd0);
            end else begin
                check("b2b_deq_val", 32'(deq_val), 32'd1);
                check("b2b_deq_msg", 32'(deq_msg), 32'(8'h10 + i - 1));
                check("b2b_num_free", 32'(num_free_entries), 32'd3);
            end
`endif
            tick();
        end
        enq_val = 1'b0;
        #1;
`ifndef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
        check("b2b_last_deq_msg", 32'(deq_msg), 32'h19);
        tick();
`endif
        check("b2b_end_deq_val", 32'(deq_val), 32'd0);
        check("b2b_end_num_free", 32'(num_free_entries), 32'd4);
        deq_rdy = 1'b0;

        // Full queue with both sides firing: only the dequeue may happen.
        for (int i = 1; i <= 4; i++) begin
            enq_val = 1'b1;
            enq_msg = 8'(8'h20 + i);
            tick();
        end
        enq_msg = 8'h25;
        deq_rdy = 1'b1;
        #1;
        check("fullboth_enq_rdy", 32'(enq_rdy), 32'd0);
        tick();
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        check("fullboth_num_free", 32'(num_free_entries), 32'd1);
        check("fullboth_head", 32'(deq_msg), 32'h22);
        deq_rdy = 1'b1;
        tick();
        deq_rdy = 1'b0;
        check("two_left_num_free", 32'(num_free_entries), 32'd2);
        check("two_left_head", 32'(deq_msg), 32'h23);

        // Asynchronous reset between edges with two entries queued.
        #2;
        reset   = 1'b1;
        enq_val = 1'b1;
        enq_msg = 8'h77;
        deq_rdy = 1'b1;
        #1;
        check("async_rst_deq_val", 32'(deq_val), 32'd0);
        check("async_rst_deq_msg", 32'(deq_msg), 32'h00);
        check("async_rst_enq_rdy", 32'(enq_rdy), 32'd1);
        check("async_rst_num_free", 32'(num_free_entries), 32'd4);
        tick();
        check("rst_edge_no_fire", 32'(num_free_entries), 32'd4);
        #3;
        reset   = 1'b0;
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        tick();
        check("post_rst_deq_val", 32'(deq_val), 32'd0);
        check("post_rst_num_free", 32'(num_free_entries), 32'd4);

        // Empty queue, message 0xAB offered with the consumer ready.
        enq_val = 1'b1;
        enq_msg = 8'hAB;
        deq_rdy = 1'b1;
        #1;
`ifdef TUT4_VERILOG_REGINCR_INPUT_QUEUE_BYPASS_EN
        check("byp_deq_val", 32'(deq_val), 32'd1);
        check("byp_deq_msg", 32'(deq_msg), 32'hAB);
        tick();
        enq_val = 1'b0;
        check("byp_num_free", 32'(num_free_entries), 32'd4);
`else
        check("nobyp_deq_val", 32'(deq_val), 32'd0);
        tick();
        enq_val = 1'b0;
        check("nobyp_next_deq_val", 32'(deq_val), 32'd1);
        check("nobyp_next_deq_msg", 32'(deq_msg), 32'hAB);
        check("nobyp_num_free", 32'(num_free_entries), 32'd3);
        tick();
        check("nobyp_after_num_free", 32'(num_free_entries), 32'd4);
`endif
        deq_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
